// File: rtl/qpsk_pkg.sv
// Shared types and symbol codes for the QPSK symbol scheduler.
package qpsk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        GAP
    } state_t;

    // Modulator phase codes
    localparam logic [1:0] SYM_0   = 2'b00;
    localparam logic [1:0] SYM_90  = 2'b01;
    localparam logic [1:0] SYM_180 = 2'b10;
    localparam logic [1:0] SYM_270 = 2'b11;

    // Preamble alternates between these, starting with the even code
    localparam logic [1:0] PRE_EVEN = SYM_0;
    localparam logic [1:0] PRE_ODD  = SYM_180;

    function automatic logic [1:0] preamble_sym(input logic odd);
        return odd ? PRE_ODD : PRE_EVEN;
    endfunction

endpackage

// File: rtl/qpsk_sym_timer.sv
// Symbol-rate tick generator: latches the rate at frame start and produces
// one tick every rate_l+1 cycles while the scheduler is active.
module qpsk_sym_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       active,
    input  logic [7:0] rate_div,
    output logic       tick
);

    logic [7:0] rate_l;
    logic [7:0] cnt;

    assign tick = active && (cnt == 8'd0);

    // Rate latch and down-counter; a fresh frame ticks on its first active cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate_l <= 8'd0;
            cnt    <= 8'd0;
        end else if (start) begin
            rate_l <= rate_div;
            cnt    <= 8'd0;
        end else if (tick) begin
            cnt <= rate_l;
        end else if (active) begin
            cnt <= cnt - 8'd1;
        end
    end

endmodule

// File: rtl/qpsk_symbol_scheduler.sv
// Frames payload bytes into QPSK symbols: preamble, MSB-first dibits, then an
// idle gap. Bytes pass through a one-byte hold register into a shift register.
module qpsk_symbol_scheduler
    import qpsk_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 8,
    parameter int unsigned GAP_LEN      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rate_div,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic [1:0] sym_out,
    output logic       sym_valid,
    output logic       busy,
    output logic       underrun
);

    localparam logic [7:0] PRE_END  = 8'(PREAMBLE_LEN);
    localparam logic [7:0] GAP_LAST = 8'(GAP_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] pre_q, pre_d;
    logic [7:0] gap_q, gap_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] shr_q, shr_d;
    logic       cur_last_q, cur_last_d;
    logic [7:0] hold_data_q;
    logic       hold_full_q, hold_last_q;
    logic       last_taken_q;
    logic [1:0] sym_out_q, sym_out_d;
    logic       sym_valid_q, sym_valid_d;
    logic       underrun_q, underrun_d;

    logic tick, start, accept, next_byte, to_gap, drain;

    assign start    = (state_q == IDLE) && s_valid;
    assign s_ready  = ((state_q == PREAMBLE) || (state_q == PAYLOAD)) && !hold_full_q
                      && !last_taken_q;
    assign accept   = s_valid && s_ready;
    assign busy     = (state_q != IDLE);
    assign sym_out   = sym_out_q;
    assign sym_valid = sym_valid_q;
    assign underrun  = underrun_q;

    qpsk_sym_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .active   (busy),
        .rate_div (rate_div),
        .tick     (tick)
    );

    // Next-state and registered-output decode; byte hand-off shared by preamble end
    // and payload byte end
    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        gap_d       = gap_q;
        idx_d       = idx_q;
        shr_d       = shr_q;
        cur_last_d  = cur_last_q;
        sym_out_d   = sym_out_q;
        sym_valid_d = 1'b0;
        underrun_d  = 1'b0;
        next_byte   = 1'b0;
        to_gap      = 1'b0;
        drain       = 1'b0;
        unique case (state_q)
            IDLE: begin
                sym_out_d = SYM_0;
                if (s_valid) begin
                    state_d = PREAMBLE;
                    pre_d   = 8'd0;
                end
            end
            PREAMBLE: begin
                if (tick) begin
                    if (pre_q != PRE_END) begin
                        sym_out_d   = preamble_sym(pre_q[0]);
                        sym_valid_d = 1'b1;
                        pre_d       = pre_q + 8'd1;
                    end else begin
                        next_byte = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (tick) begin
                    if (idx_q != 2'd0) begin
                        sym_out_d   = shr_q[7:6];
                        sym_valid_d = 1'b1;
                        shr_d       = {shr_q[5:0], 2'b00};
                        idx_d       = idx_q + 2'd1;
                    end else if (cur_last_q) begin
                        to_gap = 1'b1;
                    end else begin
                        next_byte = 1'b1;
                    end
                end
            end
            GAP: begin
                sym_out_d = SYM_0;
                if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
            end
        endcase
        if (next_byte) begin
            if (hold_full_q) begin
                // First dibit goes straight out while the rest lands in shr
                drain       = 1'b1;
                sym_out_d   = hold_data_q[7:6];
                sym_valid_d = 1'b1;
                shr_d       = {hold_data_q[5:0], 2'b00};
                cur_last_d  = hold_last_q;
                idx_d       = 2'd1;
                state_d     = PAYLOAD;
            end else begin
                underrun_d = 1'b1;
                to_gap     = 1'b1;
            end
        end
        if (to_gap) begin
            state_d   = GAP;
            gap_d     = 8'd0;
            sym_out_d = SYM_0;
        end
    end

    // Scheduler state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pre_q       <= 8'd0;
            gap_q       <= 8'd0;
            idx_q       <= 2'd0;
            shr_q       <= 8'd0;
            cur_last_q  <= 1'b0;
            sym_out_q   <= SYM_0;
            sym_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            gap_q       <= gap_d;
            idx_q       <= idx_d;
            shr_q       <= shr_d;
            cur_last_q  <= cur_last_d;
            sym_out_q   <= sym_out_d;
            sym_valid_q <= sym_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    // Hold register: a same-cycle refill wins over the drain; flushed on gap entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data_q  <= 8'd0;
            hold_full_q  <= 1'b0;
            hold_last_q  <= 1'b0;
            last_taken_q <= 1'b0;
        end else begin
            if (to_gap) begin
                hold_full_q <= 1'b0;
            end else if (accept) begin
                hold_data_q <= s_data;
                hold_last_q <= s_last;
                hold_full_q <= 1'b1;
            end else if (drain) begin
                hold_full_q <= 1'b0;
            end
            if (state_q == IDLE) begin
                last_taken_q <= 1'b0;
            end else if (accept && s_last) begin
                last_taken_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qpsk_symbol_scheduler.sv
// Directed bench for qpsk_symbol_scheduler: frames are driven byte by byte,
// strobes are logged on the falling edge and compared with hand-built lists.
module tb_qpsk_symbol_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rate_div;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic [1:0] sym_out;
    logic       sym_valid;
    logic       busy;
    logic       underrun;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int sym_q[$];
    int symc_q[$];
    int und_q[$];
    int exp_q[$];
    logic [7:0] fb[4];

    qpsk_symbol_scheduler #(
        .PREAMBLE_LEN (8),
        .GAP_LEN      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rate_div  (rate_div),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .busy      (busy),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe/underrun log, sampled mid-cycle
    always @(negedge clk) begin
        if (sym_valid) begin
            sym_q.push_back(int'(sym_out));
            symc_q.push_back(cyc);
        end
        if (underrun) und_q.push_back(cyc);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        sym_q.delete();
        symc_q.delete();
        und_q.delete();
        exp_q.delete();
    endtask

    task automatic expect_pre();
        for (int i = 0; i < 8; i++) exp_q.push_back((i % 2) ? 2 : 0);
    endtask

    // Offer fb[0..stop-1] (byte n-1 carries last); stop==0 gives a bare s_valid pulse
    task automatic drive(input int n, input int stop, output int s0);
        logic ok;
        s0 = cyc;
        if (stop == 0) begin
            s_valid = 1'b1;
            s_data  = 8'h00;
            s_last  = 1'b0;
            @(negedge clk);
            s_valid = 1'b0;
            return;
        end
        for (int i = 0; i < stop; i++) begin
            s_valid = 1'b1;
            s_data  = fb[i];
            s_last  = (i == n - 1);
            ok = 1'b0;
            for (int k = 0; k < 500; k++) begin
                ok = s_ready;
                @(negedge clk);
                if (ok) break;
            end
            check_eq($sformatf("byte%0d_accepted", i), int'(ok), 1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle(output int idle_cyc);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check_eq("idle_reached", int'(busy), 0);
        idle_cyc = cyc;
    endtask

    // Symbol list, first-strobe latency, spacing, underrun and gap length
    task automatic check_frame(input string tag, input int r, input int s0, input int n_und,
                               input int und_delta, input int idle_cyc);
        check_eq({tag, "/count"}, sym_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < sym_q.size(); i++) begin
            check_eq($sformatf("%s/sym%0d", tag, i), sym_q[i], exp_q[i]);
            if (i == 0) check_eq({tag, "/first_at"}, symc_q[0] - s0, 2);
            else check_eq($sformatf("%s/space%0d", tag, i), symc_q[i] - symc_q[i-1], r + 1);
        end
        check_eq({tag, "/underruns"}, und_q.size(), n_und);
        if (sym_q.size() > 0) begin
            if (n_und > 0 && und_q.size() > 0)
                check_eq({tag, "/underrun_at"}, und_q[0] - symc_q[symc_q.size()-1], und_delta);
            check_eq({tag, "/gap"}, idle_cyc - symc_q[symc_q.size()-1], 5 * (r + 1));
        end
    endtask

    initial begin
        int s0;
        int ic;
        reset    = 1'b1;
        rate_div = 8'd3;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        s_last   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst/s_ready", int'(s_ready), 0);
        check_eq("rst/sym_out", int'(sym_out), 0);
        check_eq("rst/sym_valid", int'(sym_valid), 0);
        check_eq("rst/busy", int'(busy), 0);
        check_eq("rst/underrun", int'(underrun), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // One byte 0xB4 with last, rate 3: 10 11 01 00 after preamble
        clr();
        rate_div = 8'd3;
        fb[0] = 8'hB4;
        drive(1, 1, s0);
        wait_idle(ic);
        expect_pre();
        exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(0);
        check_frame("b4_r3", 3, s0, 0, 0, ic);
        repeat (3) @(negedge clk);

        // Two bytes back to back at full rate: 0x1B then 0xE4(last)
        clr();
        rate_div = 8'd0;
        fb[0] = 8'h1B; fb[1] = 8'hE4;
        drive(2, 2, s0);
        wait_idle(ic);
        expect_pre();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0);
        check_frame("two_r0", 0, s0, 0, 0, ic);
        repeat (3) @(negedge clk);

        // Source stalls after byte 0 (0x6C = 01 10 11 00) of a 3-byte frame
        clr();
        rate_div = 8'd1;
        fb[0] = 8'h6C; fb[1] = 8'h55; fb[2] = 8'hAA;
        drive(3, 1, s0);
        wait_idle(ic);
        expect_pre();
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0);
        check_frame("stall_r1", 1, s0, 1, 2, ic);
        repeat (3) @(negedge clk);

        // s_valid pulse in IDLE with no byte behind it: preamble only, then underrun
        clr();
        rate_div = 8'd0;
        drive(1, 0, s0);
        wait_idle(ic);
        expect_pre();
        check_frame("nobyte_r0", 0, s0, 1, 1, ic);
        repeat (3) @(negedge clk);

        // Reset while the 2nd payload symbol is on the output
        clr();
        rate_div = 8'd3;
        fb[0] = 8'hB4;
        drive(1, 1, s0);
        for (int k = 0; k < 500; k++) begin
            if (sym_q.size() >= 10) break;
            @(negedge clk);
        end
        check_eq("rst_mid/reached_sym10", sym_q.size(), 10);
        check_eq("rst_mid/sym10_value", int'(sym_out), 3);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_mid/s_ready", int'(s_ready), 0);
        check_eq("rst_mid/sym_out", int'(sym_out), 0);
        check_eq("rst_mid/sym_valid", int'(sym_valid), 0);
        check_eq("rst_mid/busy", int'(busy), 0);
        check_eq("rst_mid/underrun", int'(underrun), 0);
        reset = 1'b0;
        clr();
        repeat (30) @(negedge clk);
        check_eq("rst_mid/no_more_syms", sym_q.size(), 0);
        check_eq("rst_mid/still_idle", int'(busy), 0);
        clr();
        drive(1, 1, s0);
        wait_idle(ic);
        expect_pre();
        exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(0);
        check_frame("after_rst", 3, s0, 0, 0, ic);
        repeat (3) @(negedge clk);

        // rate_div 2 -> 5 mid-frame keeps 3-cycle spacing; the next frame runs at 6
        clr();
        rate_div = 8'd2;
        fb[0] = 8'h1B; fb[1] = 8'hE4;
        drive(2, 2, s0);
        rate_div = 8'd5;
        wait_idle(ic);
        expect_pre();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0);
        check_frame("rate_chg_old", 2, s0, 0, 0, ic);
        repeat (3) @(negedge clk);
        clr();
        fb[0] = 8'hB4;
        drive(1, 1, s0);
        wait_idle(ic);
        expect_pre();
        exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(0);
        check_frame("rate_chg_new", 5, s0, 0, 0, ic);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
